// File: rtl/pill_sched_pkg.sv
// Shared definitions for the pill dose scheduler.
//  - chanState_t : per-channel FSM state (IDLE, COUNTING, DUE)
//  - DEF_*       : default widths and grace window used by the top level
//  - idWidth()   : channel index width, never narrower than one bit
package pill_sched_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    DUE      = 2'd2
  } chanState_t;

  localparam int DEF_NUM_PILLS = 3;
  localparam int DEF_TIME_W    = 17;
  localparam int DEF_GRACE_SEC = 900;
  localparam int DEF_MISS_W    = 8;

  // Index width for n channels; a single channel still needs a 1-bit id port.
  function automatic int idWidth(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pill_channel.sv
// One pill channel: due/missed FSM, countdown, dose interval and a saturating
// miss counter.
// Ports:
//  clk, reset      clock, synchronous active-high reset
//  secondTick      one-cycle pulse per second
//  load            accepted (already validated) program request for this channel
//  loadInterval    dose interval in seconds (nonzero)
//  loadFirstDue    seconds until the first dose
//  taken           pill-taken strobe
//  dueLed          registered: channel is DUE
//  missPulse       registered one-cycle pulse when a dose is missed
//  missCount       registered saturating miss count
//  counting        channel is COUNTING (feeds the next-pill selector)
//  countdown       current countdown value
module pill_channel
  import pill_sched_pkg::*;
#(
  parameter int TIME_W    = DEF_TIME_W,
  parameter int GRACE_SEC = DEF_GRACE_SEC,
  parameter int MISS_W    = DEF_MISS_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              secondTick,
  input  logic              load,
  input  logic [TIME_W-1:0] loadInterval,
  input  logic [TIME_W-1:0] loadFirstDue,
  input  logic              taken,
  output logic              dueLed,
  output logic              missPulse,
  output logic [MISS_W-1:0] missCount,
  output logic              counting,
  output logic [TIME_W-1:0] countdown
);

  localparam logic [TIME_W-1:0] GRACE_INIT = TIME_W'(GRACE_SEC);
  localparam logic [TIME_W-1:0] ONE_SEC    = TIME_W'(1);
  localparam logic [MISS_W-1:0] MISS_MAX   = {MISS_W{1'b1}};

  chanState_t        state_r;
  logic [TIME_W-1:0] countdown_r;
  logic [TIME_W-1:0] interval_r;
  logic [MISS_W-1:0] missCount_r;
  logic              missPulse_r;
  logic              dueLed_r;

  // Channel FSM. Priority within one cycle: reset > load > taken > secondTick.
  // dueLed_r is written alongside every DUE entry/exit so the LED is a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      countdown_r <= '0;
      interval_r  <= '0;
      missCount_r <= '0;
      missPulse_r <= 1'b0;
      dueLed_r    <= 1'b0;
    end else begin
      missPulse_r <= 1'b0;
      if (load) begin
        // Reprogramming from any state restarts the countdown; misses are kept.
        state_r     <= COUNTING;
        countdown_r <= loadFirstDue;
        interval_r  <= loadInterval;
        dueLed_r    <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= IDLE;
          end
          COUNTING: begin
            // Early doses are ignored here; only the tick moves the channel on.
            if (secondTick) begin
              if (countdown_r == '0) begin
                state_r     <= DUE;
                countdown_r <= GRACE_INIT;
                dueLed_r    <= 1'b1;
              end else begin
                countdown_r <= countdown_r - ONE_SEC;
              end
            end
          end
          DUE: begin
            if (taken) begin
              // Countdown restarts from interval-1 because the current second
              // is already part of the new interval.
              state_r     <= COUNTING;
              countdown_r <= interval_r - ONE_SEC;
              dueLed_r    <= 1'b0;
            end else if (secondTick) begin
              if (countdown_r == '0) begin
                state_r     <= COUNTING;
                countdown_r <= interval_r - ONE_SEC;
                dueLed_r    <= 1'b0;
                missPulse_r <= 1'b1;
                if (missCount_r != MISS_MAX) begin
                  missCount_r <= missCount_r + MISS_W'(1);
                end
              end else begin
                countdown_r <= countdown_r - ONE_SEC;
              end
            end
          end
          default: begin
            state_r     <= IDLE;
            countdown_r <= '0;
            dueLed_r    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dueLed    = dueLed_r;
  assign missPulse = missPulse_r;
  assign missCount = missCount_r;
  assign counting  = (state_r == COUNTING);
  assign countdown = countdown_r;

endmodule

// File: rtl/pill_dose_scheduler.sv
// N-channel pill dose scheduler: load decode and validation, per-channel FSMs
// and a registered "next pill" selector (smallest countdown among COUNTING
// channels, ties to the lowest index).
// Ports:
//  clk, reset                 clock, synchronous active-high reset
//  secondTick                 one-cycle pulse per second
//  loadValid/loadId/loadInterval/loadFirstDue  program one channel
//  loadError                  one-cycle pulse when a load is rejected
//  takenPulse                 per-channel pill-taken strobes
//  dueLEDs, missPulse         per-channel DUE flag and miss pulse
//  missCounts                 flat miss counters, channel i at [i*MISS_W +: MISS_W]
//  nextValid/nextPillId/nextPillSec  next dose to come
module pill_dose_scheduler
  import pill_sched_pkg::*;
#(
  parameter int NUM_PILLS = DEF_NUM_PILLS,
  parameter int TIME_W    = DEF_TIME_W,
  parameter int GRACE_SEC = DEF_GRACE_SEC,
  parameter int MISS_W    = DEF_MISS_W,
  parameter int ID_W      = idWidth(NUM_PILLS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        secondTick,
  input  logic                        loadValid,
  input  logic [ID_W-1:0]             loadId,
  input  logic [TIME_W-1:0]           loadInterval,
  input  logic [TIME_W-1:0]           loadFirstDue,
  output logic                        loadError,
  input  logic [NUM_PILLS-1:0]        takenPulse,
  output logic [NUM_PILLS-1:0]        dueLEDs,
  output logic [NUM_PILLS-1:0]        missPulse,
  output logic [NUM_PILLS*MISS_W-1:0] missCounts,
  output logic                        nextValid,
  output logic [ID_W-1:0]             nextPillId,
  output logic [TIME_W-1:0]           nextPillSec
);

  logic                 loadOk_s;
  logic [NUM_PILLS-1:0] chanLoad_s;
  logic [NUM_PILLS-1:0] chanCounting_s;
  logic [TIME_W-1:0]    chanCountdown_s [NUM_PILLS];

  logic                 bestValid_s;
  logic [ID_W-1:0]      bestId_s;
  logic [TIME_W-1:0]    bestSec_s;

  logic                 loadError_r;
  logic                 nextValid_r;
  logic [ID_W-1:0]      nextPillId_r;
  logic [TIME_W-1:0]    nextPillSec_r;

  // Zero interval or an out-of-range id would leave a channel unusable.
  // The id is widened by one bit so NUM_PILLS itself is representable.
  assign loadOk_s = loadValid
                    && (loadInterval != '0)
                    && ({1'b0, loadId} < (ID_W + 1)'(NUM_PILLS));

  for (genvar g = 0; g < NUM_PILLS; g++) begin : gChan
    assign chanLoad_s[g] = loadOk_s && (loadId == ID_W'(g));

    pill_channel #(
      .TIME_W    (TIME_W),
      .GRACE_SEC (GRACE_SEC),
      .MISS_W    (MISS_W)
    ) uChan (
      .clk          (clk),
      .reset        (reset),
      .secondTick   (secondTick),
      .load         (chanLoad_s[g]),
      .loadInterval (loadInterval),
      .loadFirstDue (loadFirstDue),
      .taken        (takenPulse[g]),
      .dueLed       (dueLEDs[g]),
      .missPulse    (missPulse[g]),
      .missCount    (missCounts[g*MISS_W +: MISS_W]),
      .counting     (chanCounting_s[g]),
      .countdown    (chanCountdown_s[g])
    );
  end

  // Min-reduction over COUNTING channels; strict '<' keeps the lowest index on ties.
  always_comb begin
    bestValid_s = 1'b0;
    bestId_s    = '0;
    bestSec_s   = '0;
    for (int i = 0; i < NUM_PILLS; i++) begin
      if (chanCounting_s[i] && (!bestValid_s || (chanCountdown_s[i] < bestSec_s))) begin
        bestValid_s = 1'b1;
        bestId_s    = ID_W'(i);
        bestSec_s   = chanCountdown_s[i];
      end else begin
        bestValid_s = bestValid_s;
      end
    end
  end

  // Registered load-error pulse and next-pill outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      loadError_r   <= 1'b0;
      nextValid_r   <= 1'b0;
      nextPillId_r  <= '0;
      nextPillSec_r <= '0;
    end else begin
      loadError_r   <= loadValid && !loadOk_s;
      nextValid_r   <= bestValid_s;
      nextPillId_r  <= bestId_s;
      nextPillSec_r <= bestSec_s;
    end
  end

  assign loadError   = loadError_r;
  assign nextValid   = nextValid_r;
  assign nextPillId  = nextPillId_r;
  assign nextPillSec = nextPillSec_r;

endmodule

// File: tb/tb_pill_dose_scheduler.sv
// Self-checking bench for pill_dose_scheduler (3 channels, 3 s grace window).
// The reference model tracks each channel by absolute tick numbers: the tick on
// which it becomes due, and from that the tick on which it is missed.
module tb_pill_dose_scheduler;

  localparam int N   = 3;
  localparam int TW  = 17;
  localparam int G   = 3;
  localparam int MW  = 8;
  localparam int IDW = 2;
  localparam int VW  = 2 * N + N * MW + 1 + IDW + TW + 1;
  localparam int MISS_SAT = (1 << MW) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            secondTick;
  logic            loadValid;
  logic [IDW-1:0]  loadId;
  logic [TW-1:0]   loadInterval;
  logic [TW-1:0]   loadFirstDue;
  logic            loadError;
  logic [N-1:0]    takenPulse;
  logic [N-1:0]    dueLEDs;
  logic [N-1:0]    missPulse;
  logic [N*MW-1:0] missCounts;
  logic            nextValid;
  logic [IDW-1:0]  nextPillId;
  logic [TW-1:0]   nextPillSec;

  pill_dose_scheduler #(
    .NUM_PILLS (N),
    .TIME_W    (TW),
    .GRACE_SEC (G),
    .MISS_W    (MW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .secondTick   (secondTick),
    .loadValid    (loadValid),
    .loadId       (loadId),
    .loadInterval (loadInterval),
    .loadFirstDue (loadFirstDue),
    .loadError    (loadError),
    .takenPulse   (takenPulse),
    .dueLEDs      (dueLEDs),
    .missPulse    (missPulse),
    .missCounts   (missCounts),
    .nextValid    (nextValid),
    .nextPillId   (nextPillId),
    .nextPillSec  (nextPillSec)
  );

  always #5 clk = ~clk;

  logic [VW-1:0] actVec;
  logic [VW-1:0] expVec;
  assign actVec = {dueLEDs, missPulse, missCounts, nextValid, nextPillId, nextPillSec, loadError};

  int nVec = 0;
  int nMis = 0;

  // Reference model state.
  longint tNow;
  bit     mActive  [N];
  longint mDue     [N];
  longint mInterval[N];
  int     mMissCnt [N];
  int     missEvents;

  task automatic idle();
    reset = 1'b0; secondTick = 1'b0; loadValid = 1'b0; loadId = '0;
    loadInterval = '0; loadFirstDue = '0; takenPulse = '0;
  endtask

  // Advance the model by the current inputs, then clock the DUT once.
  task automatic cycle();
    bit nv;
    int nid;
    longint nsec, rem;
    bit loadOk, lerr;
    logic [N-1:0] dueV, missV;
    logic [N*MW-1:0] cntV;
    nv = 0; nid = 0; nsec = 0;
    // Next-pill output lags channel state by one cycle: use pre-edge model.
    for (int i = 0; i < N; i++) begin
      if (mActive[i] && tNow < mDue[i]) begin
        rem = mDue[i] - tNow - 1;
        if (!nv || rem < nsec) begin nv = 1; nid = i; nsec = rem; end
      end
    end
    loadOk = loadValid && (loadInterval != 0) && (int'(loadId) < N);
    lerr   = !reset && loadValid && !loadOk;
    missV  = '0;
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        mActive[i] = 0; mDue[i] = 0; mInterval[i] = 0; mMissCnt[i] = 0;
      end else if (loadOk && int'(loadId) == i) begin
        mActive[i]   = 1;
        mInterval[i] = longint'(loadInterval);
        mDue[i]      = tNow + longint'(secondTick) + longint'(loadFirstDue) + 1;
      end else if (mActive[i] && takenPulse[i] && tNow >= mDue[i]) begin
        mDue[i] = tNow + longint'(secondTick) + mInterval[i];
      end else if (mActive[i] && secondTick && (tNow + 1 == mDue[i] + G + 1)) begin
        missV[i] = 1'b1;
        missEvents++;
        if (mMissCnt[i] < MISS_SAT) mMissCnt[i]++;
        mDue[i] = tNow + 1 + mInterval[i];
      end
    end
    tNow = reset ? 0 : tNow + longint'(secondTick);
    for (int i = 0; i < N; i++) begin
      dueV[i] = mActive[i] && (tNow >= mDue[i]);
      cntV[i*MW +: MW] = MW'(mMissCnt[i]);
    end
    if (reset) begin nv = 0; nid = 0; nsec = 0; end
    expVec = {dueV, missV, cntV, nv, IDW'(nid), TW'(nsec), lerr};
    @(posedge clk);
    #1;
  endtask

  task automatic tickCycle();
    secondTick = 1'b1; cycle(); secondTick = 1'b0;
  endtask

  task automatic doLoad(input int id, input int iv, input int fd);
    loadValid = 1'b1; loadId = IDW'(id); loadInterval = TW'(iv); loadFirstDue = TW'(fd);
    cycle();
    idle();
  endtask

  task automatic doReset();
    idle(); reset = 1'b1; cycle(); cycle(); reset = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    nVec++;
    if (actVec !== '0) begin
      nMis++; $display("FAIL reset_state: got %h expected 0", actVec);
    end
    for (int k = 0; k < 100; k++) tickCycle();
    nVec++;
    if (actVec !== expVec || actVec !== '0) begin
      nMis++; $display("FAIL idle_100_ticks: got %h expected 0", actVec);
    end
  endtask

  task automatic test_basic();
    doLoad(1, 5, 2);
    for (int k = 1; k <= 3; k++) begin
      tickCycle();
      nVec++;
      if (dueLEDs !== ((k == 3) ? 3'b010 : 3'b000)) begin
        nMis++; $display("FAIL due_rise tick%0d: got %b expected %b", k, dueLEDs,
                         (k == 3) ? 3'b010 : 3'b000);
      end
    end
    takenPulse = 3'b010; cycle(); takenPulse = 3'b000;
    nVec++;
    if (dueLEDs !== 3'b000) begin
      nMis++; $display("FAIL taken_drop: got %b expected 000", dueLEDs);
    end
    cycle();
    nVec++;
    if ({nextValid, nextPillId, nextPillSec} !== {1'b1, 2'd1, 17'd4}) begin
      nMis++; $display("FAIL next_after_taken: got v%b id%0d sec%0d expected v1 id1 sec4",
                       nextValid, nextPillId, nextPillSec);
    end
  endtask

  task automatic test_miss_saturate();
    int k;
    missEvents = 0;
    k = 0;
    while (dueLEDs[1] !== 1'b1 && k < 20) begin tickCycle(); k++; end
    nVec++;
    if (dueLEDs[1] !== 1'b1) begin
      nMis++; $display("FAIL due_wait_timeout: got %b expected 1", dueLEDs[1]);
    end
    for (int t = 1; t <= 4; t++) begin
      tickCycle();
      nVec++;
      if (missPulse !== ((t == 4) ? 3'b010 : 3'b000) || actVec !== expVec) begin
        nMis++; $display("FAIL grace_tick%0d: got miss=%b vec=%h expected miss=%b vec=%h",
                         t, missPulse, actVec, (t == 4) ? 3'b010 : 3'b000, expVec);
      end
    end
    nVec++;
    if (missCounts[15:8] !== 8'd1) begin
      nMis++; $display("FAIL miss_count_one: got %0d expected 1", missCounts[15:8]);
    end
    doLoad(1, 1, 1);
    for (int c = 0; c < 4000 && missEvents < 300; c++) begin
      tickCycle();
      nVec++;
      if (actVec !== expVec) begin
        nMis++; $display("FAIL sat_run cyc%0d: got %h expected %h", c, actVec, expVec);
      end
    end
    nVec++;
    if (missEvents < 300 || missCounts[15:8] !== 8'd255) begin
      nMis++; $display("FAIL miss_saturate: got count %0d after %0d misses expected 255 after 300",
                       missCounts[15:8], missEvents);
    end
  endtask

  task automatic test_tie();
    doReset();
    doLoad(0, 10, 7);
    doLoad(2, 10, 7);
    cycle();
    nVec++;
    if ({nextValid, nextPillId, nextPillSec} !== {1'b1, 2'd0, 17'd7}) begin
      nMis++; $display("FAIL tie_low_index: got v%b id%0d sec%0d expected v1 id0 sec7",
                       nextValid, nextPillId, nextPillSec);
    end
    doLoad(2, 10, 3);
    cycle();
    nVec++;
    if ({nextValid, nextPillId, nextPillSec} !== {1'b1, 2'd2, 17'd3}) begin
      nMis++; $display("FAIL reload_min: got v%b id%0d sec%0d expected v1 id2 sec3",
                       nextValid, nextPillId, nextPillSec);
    end
  endtask

  task automatic test_same_cycle();
    doReset();
    doLoad(1, 5, 1);
    tickCycle(); tickCycle();
    for (int k = 0; k < 3; k++) tickCycle();
    nVec++;
    if (dueLEDs !== 3'b010 || missPulse !== 3'b000) begin
      nMis++; $display("FAIL grace_end_due: got due=%b miss=%b expected due=010 miss=000",
                       dueLEDs, missPulse);
    end
    takenPulse = 3'b010; secondTick = 1'b1; cycle(); idle();
    nVec++;
    if ({dueLEDs, missPulse, missCounts[15:8]} !== {3'b000, 3'b000, 8'd0}) begin
      nMis++; $display("FAIL taken_beats_tick: got due=%b miss=%b cnt=%0d expected 000 000 0",
                       dueLEDs, missPulse, missCounts[15:8]);
    end
    loadValid = 1'b1; loadId = 2'd2; loadInterval = 17'd4; loadFirstDue = 17'd2;
    secondTick = 1'b1;
    cycle();
    idle();
    cycle();
    nVec++;
    if ({nextValid, nextPillId, nextPillSec} !== {1'b1, 2'd2, 17'd2}) begin
      nMis++; $display("FAIL load_beats_tick: got v%b id%0d sec%0d expected v1 id2 sec2",
                       nextValid, nextPillId, nextPillSec);
    end
  endtask

  task automatic test_load_error();
    doLoad(1, 0, 9);
    nVec++;
    if (loadError !== 1'b1 || actVec !== expVec) begin
      nMis++; $display("FAIL err_zero_interval: got err=%b vec=%h expected err=1 vec=%h",
                       loadError, actVec, expVec);
    end
    cycle();
    nVec++;
    if ({loadError, nextValid, nextPillId, nextPillSec} !== {1'b0, 1'b1, 2'd2, 17'd2}) begin
      nMis++; $display("FAIL err_state_kept: got err=%b v%b id%0d sec%0d expected 0 v1 id2 sec2",
                       loadError, nextValid, nextPillId, nextPillSec);
    end
    doLoad(3, 5, 1);
    nVec++;
    if (loadError !== 1'b1) begin
      nMis++; $display("FAIL err_bad_id: got %b expected 1", loadError);
    end
    cycle();
    nVec++;
    if ({loadError, nextPillId, nextPillSec} !== {1'b0, 2'd2, 17'd2} || actVec !== expVec) begin
      nMis++; $display("FAIL err_bad_id_after: got %h expected %h", actVec, expVec);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      reset        = ($urandom_range(0, 199) == 0);
      secondTick   = $urandom_range(0, 1) == 1;
      loadValid    = ($urandom_range(0, 7) == 0);
      loadId       = IDW'($urandom_range(0, 3));
      loadInterval = TW'($urandom_range(0, 6));
      loadFirstDue = TW'($urandom_range(1, 12));
      for (int b = 0; b < N; b++) takenPulse[b] = ($urandom_range(0, 3) == 0);
      cycle();
      nVec++;
      if (actVec !== expVec) begin
        nMis++; $display("FAIL random cyc%0d: got %h expected %h", c, actVec, expVec);
      end
    end
    idle();
  endtask

  initial begin
    tNow = 0;
    missEvents = 0;
    for (int i = 0; i < N; i++) begin
      mActive[i] = 0; mDue[i] = 0; mInterval[i] = 0; mMissCnt[i] = 0;
    end
    idle();
    test_reset();
    test_basic();
    test_miss_saturate();
    test_tie();
    test_same_cycle();
    test_load_error();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
